// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache, one word per line.
// Refills from the backing memory bus on miss; fence.i flush; hit/miss counters.
module inst_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_mem_out_addr,
  input  logic        inst_mem_out_valid,
  output logic [31:0] inst_mem_out_data,
  output logic        inst_mem_out_ready,
  input  logic        flush,
  output logic [31:0] mem_addr,
  output logic        mem_valid,
  input  logic [31:0] mem_data,
  input  logic        mem_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_BITS = 32 - INDEX_BITS - 2;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    RESPOND
  } state_t;

  state_t             state_q, state_d;
  logic [31:2]        addr_q, addr_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        maddr_q, maddr_d;
  logic [31:0]        hit_q, hit_d;
  logic [31:0]        miss_q, miss_d;
  logic               fpend_q, fpend_d;

  logic [31:0]         data_arr [LINES];
  logic [TAG_BITS-1:0] tag_arr [LINES];
  logic [31:0]         rd_data;
  logic [TAG_BITS-1:0] rd_tag;

  logic arr_re;
  logic arr_we;
  logic hit;
  logic unused;

  logic [INDEX_BITS-1:0] idx;
  logic [INDEX_BITS-1:0] rd_idx;
  logic [TAG_BITS-1:0]   tag;

  assign idx    = addr_q[INDEX_BITS+1:2];
  assign tag    = addr_q[31:INDEX_BITS+2];
  assign rd_idx = inst_mem_out_addr[INDEX_BITS+1:2];
  assign unused = ^inst_mem_out_addr[1:0];
  assign hit    = valid_q[idx] && (rd_tag == tag);

  assign inst_mem_out_data  = data_q;
  assign inst_mem_out_ready = (state_q == RESPOND);
  assign mem_addr   = maddr_q;
  assign mem_valid  = (state_q == REFILL);
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // Line storage: synchronous read on accept, write on refill completion.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_arr[idx] <= mem_data;
      tag_arr[idx]  <= tag;
    end
    if (arr_re) begin
      rd_data <= data_arr[rd_idx];
      rd_tag  <= tag_arr[rd_idx];
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= '0;
      data_q  <= '0;
      maddr_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      fpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      maddr_q <= maddr_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      fpend_q <= fpend_d;
    end
  end

  // Next-state logic; a flush outside IDLE is deferred until IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    data_d  = data_q;
    maddr_d = maddr_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    fpend_d = fpend_q;
    arr_re  = 1'b0;
    arr_we  = 1'b0;
    if (flush && state_q != IDLE) begin
      fpend_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (flush || fpend_q) begin
          valid_d = '0;
          fpend_d = 1'b0;
        end else if (inst_mem_out_valid) begin
          addr_d  = inst_mem_out_addr[31:2];
          arr_re  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          data_d  = rd_data;
          hit_d   = hit_q + 32'd1;
          state_d = RESPOND;
        end else begin
          miss_d  = miss_q + 32'd1;
          maddr_d = {addr_q, 2'b00};
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem_ready) begin
          arr_we       = 1'b1;
          valid_d[idx] = 1'b1;
          data_d       = mem_data;
          state_d      = RESPOND;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: table of fetch transactions
// plus hand sequences for reset state and reset mid-refill.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] f_addr = '0;
  logic        f_valid = 1'b0;
  logic [31:0] f_data;
  logic        f_ready;
  logic        flush = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  inst_cache #(.INDEX_BITS(6)) dut (
    .clk                (clk),
    .reset              (reset),
    .inst_mem_out_addr  (f_addr),
    .inst_mem_out_valid (f_valid),
    .inst_mem_out_data  (f_data),
    .inst_mem_out_ready (f_ready),
    .flush              (flush),
    .mem_addr           (mem_addr),
    .mem_valid          (mem_valid),
    .mem_data           (mem_data),
    .mem_ready          (mem_ready),
    .hit_count          (hit_count),
    .miss_count         (miss_count)
  );

  typedef struct {
    logic [31:0] addr;
    int          lat;
    logic [31:0] data;
    int          flush_at;
    bit          miss;
    logic [31:0] maddr;
    logic [31:0] hc;
    logic [31:0] mc;
  } vec_t;

  vec_t tbl [15];
  vec_t tbl2 [2];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int cyc;
    int mcnt;
    int rcyc;
    int mrcyc;
    logic abad;
    logic [31:0] rdata;
    cyc = 0;
    mcnt = 0;
    rcyc = -1;
    mrcyc = -1;
    abad = 1'b0;
    rdata = '0;
    @(posedge clk);
    #1;
    f_valid = 1'b1;
    f_addr = v.addr;
    while (rcyc < 0 && cyc < 200) begin
      @(negedge clk);
      flush = (cyc == v.flush_at);
      mem_ready = 1'b0;
      if (mem_valid) begin
        mcnt++;
        if (mem_addr !== v.maddr) abad = 1'b1;
        if (mcnt > v.lat) begin
          mem_ready = 1'b1;
          mem_data = v.data;
          mrcyc = cyc;
        end
      end
      if (f_ready) begin
        rcyc = cyc;
        rdata = f_data;
        f_valid = 1'b0;
      end
      cyc++;
    end
    f_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    mem_ready = 1'b0;
    chk($sformatf("v%0d timeout", n), 32'(rcyc >= 0), 32'd1);
    chk($sformatf("v%0d one_pulse", n), 32'(f_ready), 32'd0);
    chk($sformatf("v%0d miss", n), 32'(mcnt > 0), 32'(v.miss));
    chk($sformatf("v%0d data", n), rdata, v.data);
    if (v.miss) begin
      chk($sformatf("v%0d latency", n), rcyc, mrcyc + 1);
      chk($sformatf("v%0d mem_addr", n), 32'(abad), 32'd0);
      chk($sformatf("v%0d mem_cycles", n), mcnt, v.lat + 1);
    end else begin
      chk($sformatf("v%0d latency", n), rcyc, 2);
    end
    chk($sformatf("v%0d hit_count", n), hit_count, v.hc);
    chk($sformatf("v%0d miss_count", n), miss_count, v.mc);
  endtask

  initial begin
    tbl[0]  = '{32'h0000_0100, 3, 32'h0050_0093, -1, 1, 32'h0000_0100, 0, 1};
    tbl[1]  = '{32'h0000_0100, 0, 32'h0050_0093, -1, 0, 32'h0000_0100, 1, 1};
    tbl[2]  = '{32'h0000_0200, 1, 32'h00a0_0113, -1, 1, 32'h0000_0200, 1, 2};
    tbl[3]  = '{32'h0000_0100, 2, 32'h0050_0093, -1, 1, 32'h0000_0100, 1, 3};
    tbl[4]  = '{32'h0000_0104, 2, 32'h0010_0193,  3, 1, 32'h0000_0104, 1, 4};
    tbl[5]  = '{32'h0000_0104, 1, 32'h0010_0193, -1, 1, 32'h0000_0104, 1, 5};
    tbl[6]  = '{32'h0000_0104, 0, 32'h0010_0193, -1, 0, 32'h0000_0104, 2, 5};
    tbl[7]  = '{32'h0000_0103, 20, 32'h1234_5678, -1, 1, 32'h0000_0100, 2, 6};
    tbl[8]  = '{32'h0000_0100, 0, 32'h1234_5678, -1, 0, 32'h0000_0100, 3, 6};
    tbl[9]  = '{32'hffff_fffc, 1, 32'hdead_beef, -1, 1, 32'hffff_fffc, 3, 7};
    tbl[10] = '{32'hffff_fffe, 0, 32'hdead_beef, -1, 0, 32'hffff_fffc, 4, 7};
    tbl[11] = '{32'h0000_0100, 1, 32'h1234_5678,  0, 1, 32'h0000_0100, 4, 8};
    tbl[12] = '{32'hffff_fffc, 1, 32'hdead_beef, -1, 1, 32'hffff_fffc, 4, 9};
    tbl[13] = '{32'h0000_0200, 0, 32'h00a0_0113,  2, 1, 32'h0000_0200, 4, 10};
    tbl[14] = '{32'h0000_0200, 1, 32'h00a0_0113, -1, 1, 32'h0000_0200, 4, 11};
    tbl2[0] = '{32'h0000_0300, 2, 32'h0000_0013, -1, 1, 32'h0000_0300, 0, 1};
    tbl2[1] = '{32'h0000_0300, 0, 32'h0000_0013, -1, 0, 32'h0000_0300, 1, 1};

    #12;
    chk("rst ready", 32'(f_ready), 32'd0);
    chk("rst data", f_data, 32'd0);
    chk("rst mem_valid", 32'(mem_valid), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst hit_count", hit_count, 32'd0);
    chk("rst miss_count", miss_count, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_vec(i, tbl[i]);
    end

    // Reset while a refill is outstanding.
    @(posedge clk);
    #1;
    f_valid = 1'b1;
    f_addr = 32'h0000_0300;
    repeat (4) @(negedge clk);
    chk("mid mem_valid", 32'(mem_valid), 32'd1);
    reset = 1'b0;
    #1;
    f_valid = 1'b0;
    chk("mid rst mem_valid", 32'(mem_valid), 32'd0);
    chk("mid rst mem_addr", mem_addr, 32'd0);
    chk("mid rst data", f_data, 32'd0);
    chk("mid rst hit_count", hit_count, 32'd0);
    chk("mid rst miss_count", miss_count, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 2; i++) begin
      run_vec(100 + i, tbl2[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache with one 32-bit word per line.
- Sits directly downstream of the core's fetch stage. It serves the fetcher's request/ready handshake and refills from a slower backing instruction-memory bus on a miss.
- Also provides a flush for fence.i and hit/miss counters.

Parameters:
- INDEX_BITS, 6: log2 of the line count (default 64 lines).
- TAG_BITS, 32-INDEX_BITS-2: derived, not overridable. Tag width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst_mem_out_addr  in  32  fetch address from the fetcher; bits [1:0] ignored.
- inst_mem_out_valid  in  1  fetch request; held high by the fetcher until it samples ready.
- inst_mem_out_data  out  32  instruction word; valid only while inst_mem_out_ready=1.
- inst_mem_out_ready  out  1  one-cycle response strobe.
- flush  in  1  single-cycle pulse; invalidates all lines.
- mem_addr  out  32  backing-memory word address; bits [1:0]=0.
- mem_valid  out  1  backing-memory read request.
- mem_data  in  32  backing-memory read data; valid when mem_ready=1.
- mem_ready  in  1  backing-memory completion; data is returned in the same cycle.
- hit_count  out  32  hits since reset; wraps modulo 2^32.
- miss_count  out  32  misses since reset; wraps modulo 2^32.

Behaviour:
- Address split: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].
- Storage: data array and tag array use synchronous read. Valid bits are a flop vector.
- Reset (reset=0, async), all take effect immediately:
  - state goes to IDLE; all valid bits 0;
  - inst_mem_out_ready=0, inst_mem_out_data=0;
  - mem_valid=0, mem_addr=0;
  - hit_count=0, miss_count=0; flush_pending=0.
- Data/tag array contents are not reset.
- FSM states: IDLE, LOOKUP, REFILL, RESPOND.
- IDLE:
  - If flush or flush_pending: clear all valid bits this cycle, clear flush_pending, accept no request, stay in IDLE.
  - Else if inst_mem_out_valid: register the address, issue the array read at its index, go to LOOKUP.
- LOOKUP:
  - Hit = valid[index] and stored tag == registered tag.
  - On hit: load inst_mem_out_data with the array data, increment hit_count, go to RESPOND.
  - On miss: increment miss_count, go to REFILL with mem_valid=1 and mem_addr={addr[31:2],2'b00} registered.
- REFILL:
  - Hold mem_valid and mem_addr stable until mem_ready=1.
  - On mem_ready: write mem_data and the tag into the line, set valid[index], load inst_mem_out_data=mem_data, drop mem_valid, go to RESPOND.
  - Stall length is unbounded.
- RESPOND: inst_mem_out_ready=1 for exactly this one cycle, then go to IDLE. The fetcher drops valid on the following cycle, so no request is re-accepted.
- Latency, counted from the first cycle inst_mem_out_valid=1 in IDLE:
  - Hit: ready at cycle +2.
  - Miss: ready at cycle (cycle mem_ready high) +1.
- inst_mem_out_ready is never high outside RESPOND.
- Changes to inst_mem_out_addr after acceptance are ignored until the next IDLE acceptance.
- Flush outside IDLE: set flush_pending. The in-flight request completes normally, including its line write; invalidation is applied on the next IDLE cycle.
- Flush in IDLE with valid high: flush wins. The request is accepted on the following cycle and sees an empty cache.
- Flush in the REFILL cycle where mem_ready=1: the line is written, then invalidated on return to IDLE.
- Reset mid-REFILL: mem_valid drops asynchronously, the transaction is abandoned, and no line is written. The memory side must tolerate an abandoned request.
- Counters increment only in LOOKUP and wrap at 2^32.

Test Plan:
- Cold miss: after reset, request addr 0x00000100; mem_ready asserted 3 cycles after mem_valid with data 0x00500093.
  -> mem_addr=0x00000100; ready exactly one cycle with data 0x00500093; miss_count=1, hit_count=0.
- Hit: repeat request 0x00000100 after the cold miss.
  -> no mem_valid; ready 2 cycles after valid with 0x00500093; hit_count=1.
- Conflict: with INDEX_BITS=6, fill 0x00000100, then request 0x00000200 (same index 0).
  -> miss with mem_addr=0x00000200; a following request to 0x00000100 misses again; miss_count=3.
- Flush: flush pulse during REFILL of 0x00000104.
  -> that request returns the correct data; the next request to 0x00000104 misses.
- Reset mid-refill: drop reset while mem_valid=1, before mem_ready.
  -> mem_valid=0 immediately, counters=0; after release, a request to the same address misses.
- Misaligned/stall: request 0x00000103 with mem_ready held low for 20 cycles.
  -> mem_addr=0x00000100 and mem_valid stable all 20 cycles; ready never asserts early; one ready pulse after mem_ready.
